seq_detect_prog: RTL and testbench

Runtime-programmable serial bit-sequence detector and the parametrised successor of the team's fixed single-pattern detector.
- Pattern and length (1..MAX_LEN) are loadable at runtime.
- Overlapping and non-overlapping detection are selectable.
- Input bits are gated by a valid strobe.
- Output is a registered match pulse plus a saturating match counter.
- Sits between a serial deserialiser/bit source and status logic.

---
 rtl/seq_detect_pkg.sv | 26 ++
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detect_prog.sv | 103 ++++++++++
 tb/tb_seq_detect_prog.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types, defaults and helpers for the programmable sequence detector.
package seq_detect_pkg;

    // FILL: fewer than len bits collected; ARMED: a full window is available.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam logic [7:0]  DEF_PATTERN = 8'b0000_1011;
    localparam int unsigned DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Map a requested length onto the legal range 1..max_len.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count up on inc, hold at all-ones, clear on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector with overlap control,
// a registered match pulse and a saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int unsigned        MAX_LEN         = DEF_MAX_LEN,
    parameter int unsigned        CNT_W           = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned        DEFAULT_LEN     = DEF_LEN,
    parameter logic               DEFAULT_OVERLAP = DEF_OVERLAP,
    parameter int unsigned        LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               match,
    output logic               armed,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] RstLen = LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));

    state_e             r_state;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_match;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;

    // Next history/fill for an accepted bit and the resulting match decision.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < 32'(r_len));
        end
        // Truncating cast drops the oldest bit; works for MAX_LEN == 1 too.
        w_hist_next = MAX_LEN'({r_hist, bit_in});
        w_fill_next = (r_fill == r_len) ? r_fill : r_fill + LEN_W'(1);
        w_hit       = (w_fill_next == r_len) &&
                      ((w_hist_next & w_mask) == (r_pattern & w_mask));
    end

    // Configuration, shift register, fill/state FSM and registered match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= DEFAULT_PATTERN;
            r_len     <= RstLen;
            r_overlap <= DEFAULT_OVERLAP;
            r_match   <= 1'b0;
        end else if (cfg_load) begin
            // A bit offered in the same cycle as a load is dropped.
            r_pattern <= cfg_pattern;
            r_len     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            r_overlap <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= FILL;
            r_match   <= 1'b0;
        end else if (bit_valid) begin
            r_hist  <= w_hist_next;
            r_match <= w_hit;
            if (w_hit && !r_overlap) begin
                // Old history stays but is ignored until len fresh bits arrive.
                r_fill  <= '0;
                r_state <= FILL;
            end else begin
                r_fill  <= w_fill_next;
                r_state <= (w_fill_next == r_len) ? ARMED : FILL;
            end
        end else begin
            r_match <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (r_match),
        .clr   (count_clr),
        .count (match_count)
    );

    assign match = r_match;
    assign armed = (r_state == ARMED);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// long randomized run compared every cycle against a queue-based model.
module tb_seq_detect_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic               clk         = 1'b0;
    logic               rst_n       = 1'b0;
    logic               bit_valid   = 1'b0;
    logic               bit_in      = 1'b0;
    logic               cfg_load    = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len     = '0;
    logic               cfg_overlap = 1'b0;
    logic               count_clr   = 1'b0;
    logic               match;
    logic               armed;
    logic [CNT_W-1:0]   match_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: bits collected since the last load / reset / non-overlap match.
    bit         m_q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_match;
    int         m_cnt;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .match       (match),
        .armed       (armed),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_pat   = 8'b0000_1011;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_match = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_step();
        bit hit;
        if (count_clr) m_cnt = 0;
        else if (m_match && m_cnt < CNT_MAX) m_cnt++;
        if (cfg_load) begin
            m_pat   = cfg_pattern;
            m_len   = (cfg_len == 0) ? 1 : (cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl   = cfg_overlap;
            m_q.delete();
            m_match = 1'b0;
        end else if (bit_valid) begin
            m_q.push_back(bit_in);
            if (m_q.size() > m_len) void'(m_q.pop_front());
            hit = 1'b0;
            if (m_q.size() == m_len) begin
                hit = 1'b1;
                // Oldest queued bit is compared with pattern bit [len-1].
                for (int i = 0; i < m_len; i++) begin
                    if (m_q[i] != m_pat[m_len-1-i]) hit = 1'b0;
                end
            end
            m_match = hit;
            if (hit && !m_ovl) m_q.delete();
        end else begin
            m_match = 1'b0;
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_match", match, m_match);
                chk("model_armed", armed, (m_q.size() == m_len));
                chk("model_count", match_count, m_cnt);
            end
        end
    end

    task automatic drive_bit(input bit b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                        input bit bv, input bit b);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        bit_valid   = bv;
        bit_in      = b;
        @(negedge clk);
        cfg_load  = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
    endtask

    initial begin
        bit s1[7]  = '{1, 0, 1, 1, 0, 1, 1};
        bit e1m[7] = '{0, 0, 0, 1, 0, 0, 1};
        bit e1a[7] = '{0, 0, 0, 1, 1, 1, 1};
        bit s2[5]  = '{1, 0, 1, 0, 1};
        bit e2o[5] = '{0, 0, 1, 0, 1};
        bit e2n[5] = '{0, 0, 1, 0, 0};
        bit s6[8]  = '{1, 0, 1, 1, 0, 0, 1, 0};

        // Reset state
        idle(2);
        chk("rst_match", match, 0);
        chk("rst_armed", armed, 0);
        chk("rst_count", match_count, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Default pattern 1011, overlapping
        for (int i = 0; i < 7; i++) begin
            drive_bit(s1[i]);
            chk($sformatf("t1_match_b%0d", i + 1), match, e1m[i]);
            chk($sformatf("t1_armed_b%0d", i + 1), armed, e1a[i]);
        end
        idle(1);
        chk("t1_count", match_count, 2);
        chk("t1_model_count", m_cnt, 2);

        // Pattern 101 len 3, overlap then non-overlap
        clr();
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        chk("t2_armed_after_load", armed, 0);
        for (int i = 0; i < 5; i++) begin
            drive_bit(s2[i]);
            chk($sformatf("t2o_match_b%0d", i + 1), match, e2o[i]);
        end
        load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_bit(s2[i]);
            chk($sformatf("t2n_match_b%0d", i + 1), match, e2n[i]);
        end
        idle(1);
        chk("t2_count", match_count, 3);

        // len 1 pattern 0; upper pattern bits set but ignored
        load(8'hFE, 4'd1, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0);
        chk("t3_match_b1", match, 1);
        drive_bit(1'b1);
        chk("t3_match_b2", match, 0);
        idle(1);
        chk("t3_match_gap", match, 0);
        drive_bit(1'b0);
        chk("t3_match_b3", match, 1);
        drive_bit(1'b0);
        chk("t3_match_b4", match, 1);

        // Saturation and clear priority
        clr();
        load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        repeat (17) drive_bit(1'b1);
        idle(2);
        chk("t4_count_sat", match_count, 15);
        clr();
        chk("t4_count_clr", match_count, 0);
        drive_bit(1'b1);
        chk("t4_match_at_clr", match, 1);
        clr();
        chk("t4_clr_beats_inc", match_count, 0);

        // Asynchronous reset mid-stream
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_match", match, 0);
        chk("t5_rst_armed", armed, 0);
        chk("t5_rst_count", match_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1);
        chk("t5_match_after", match, 0);
        chk("t5_armed_after", armed, 0);

        // Load with simultaneous bit, length clamped to 8, non-overlap
        load(8'b1011_0010, 4'd12, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive_bit(s6[i]);
            chk($sformatf("t6_match_b%0d", i + 1), match, (i == 7));
            chk($sformatf("t6_armed_b%0d", i + 1), armed, 0);
        end

        // Randomized run; inputs change 1 time unit after the sampling edge
        #1;
        for (int n = 0; n < 4000; n++) begin
            rst_n       = ($urandom_range(0, 499) != 0);
            cfg_load    = ($urandom_range(0, 49) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 3));
            cfg_overlap = 1'($urandom_range(0, 1));
            count_clr   = ($urandom_range(0, 63) == 0);
            bit_valid   = ($urandom_range(0, 9) < 7);
            bit_in      = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
        end
        rst_n     = 1'b1;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
        bit_valid = 1'b0;
        idle(2);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
